// File: rtl/rf_wr_arbiter.sv
// Two-requester register-file write arbiter with one-entry buffers.
// Optional round-robin on different-register conflicts: RF_ARB_RR_EN.
module rf_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [SEL_W-1:0]       a_sel,
  input  logic [DATA_W-1:0]      a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [SEL_W-1:0]       b_sel,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   b_ready,
  output logic                   wr_en,
  output logic [SEL_W-1:0]       wr_sel,
  output logic [DATA_W-1:0]      wr_data,
  output logic [(1<<SEL_W)-1:0]  pend_mask,
  output logic                   busy
);

  logic              a_full_q, a_full_d;
  logic [SEL_W-1:0]  a_sel_q, a_sel_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [SEL_W-1:0]  b_sel_q, b_sel_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              age_q, age_d;
  logic              wr_en_q, wr_en_d;
  logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic both, same, a_prio;
  logic grant_a, grant_b, grant_any;
  logic a_acc, b_acc;

  assign both = a_full_q & b_full_q;
  assign same = (a_sel_q == b_sel_q);

`ifdef RF_ARB_RR_EN
  logic rr_q, rr_d;
  assign a_prio = ~rr_q;
`else
  assign a_prio = 1'b1;
`endif

  // age_q=1 means the B entry is older
  assign grant_a   = a_full_q & (~b_full_q | (same ? ~age_q : a_prio));
  assign grant_b   = b_full_q & ~grant_a;
  assign grant_any = grant_a | grant_b;

  assign a_ready = rst & (~a_full_q | grant_a);
  assign b_ready = rst & (~b_full_q | grant_b);
  assign a_acc   = a_valid & a_ready;
  assign b_acc   = b_valid & b_ready;

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;
  assign busy    = a_full_q | b_full_q | wr_en_q;

  // buffer drain/refill, age tracking and output stage next state
  always_comb begin
    a_full_d  = a_full_q;
    a_sel_d   = a_sel_q;
    a_data_d  = a_data_q;
    b_full_d  = b_full_q;
    b_sel_d   = b_sel_q;
    b_data_d  = b_data_q;
    age_d     = age_q;
    wr_en_d   = grant_any;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    if (grant_a) begin
      a_full_d  = 1'b0;
      wr_sel_d  = a_sel_q;
      wr_data_d = a_data_q;
    end else if (grant_b) begin
      b_full_d  = 1'b0;
      wr_sel_d  = b_sel_q;
      wr_data_d = b_data_q;
    end
    if (a_acc) begin
      a_full_d = 1'b1;
      a_sel_d  = a_sel;
      a_data_d = a_data;
    end
    if (b_acc) begin
      b_full_d = 1'b1;
      b_sel_d  = b_sel;
      b_data_d = b_data;
    end
    if (a_acc && b_acc) age_d = 1'b0;
    else if (a_acc)     age_d = 1'b1;
    else if (b_acc)     age_d = 1'b0;
  end

`ifdef RF_ARB_RR_EN
  // pointer moves to the loser after a different-register conflict
  always_comb begin
    rr_d = rr_q;
    if (both && !same) rr_d = grant_a;
  end

  // round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`endif

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_full_q  <= 1'b0;
      a_sel_q   <= '0;
      a_data_q  <= '0;
      b_full_q  <= 1'b0;
      b_sel_q   <= '0;
      b_data_q  <= '0;
      age_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      a_full_q  <= a_full_d;
      a_sel_q   <= a_sel_d;
      a_data_q  <= a_data_d;
      b_full_q  <= b_full_d;
      b_sel_q   <= b_sel_d;
      b_data_q  <= b_data_d;
      age_q     <= age_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  // pending-write mask for decode hazard checks
  always_comb begin
    pend_mask = '0;
    if (a_full_q) pend_mask[a_sel_q]  = 1'b1;
    if (b_full_q) pend_mask[b_sel_q]  = 1'b1;
    if (wr_en_q)  pend_mask[wr_sel_q] = 1'b1;
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios plus random traffic
// against a timestamp-based reference model.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0]  a_sel = '0, b_sel = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, wr_en, busy;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic [7:0]  pend_mask;

  rf_wr_arbiter #(.DATA_W(16), .SEL_W(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .pend_mask(pend_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: each buffer holds an entry stamped with its arrival cycle
  bit          ma_full, mb_full;
  logic [2:0]  ma_sel, mb_sel;
  logic [15:0] ma_data, mb_data;
  int          ma_t, mb_t;
  bit          m_en;
  logic [2:0]  m_sel;
  logic [15:0] m_data;
  bit          m_rrb;
  int          cyc;
  int          accepted, retired;
  bit          hold_a, hold_b;
  logic [2:0]  pa_sel, pb_sel;
  logic [15:0] pa_data, pb_data;

  task automatic model_clear();
    ma_full = 0; mb_full = 0;
    ma_sel = '0; mb_sel = '0;
    ma_data = '0; mb_data = '0;
    ma_t = 0; mb_t = 0;
    m_en = 0; m_sel = '0; m_data = '0;
    m_rrb = 0;
    accepted = 0; retired = 0;
    hold_a = 0; hold_b = 0;
  endtask

  // 0 none, 1 A, 2 B
  function automatic int pick();
    if (ma_full && mb_full) begin
      if (ma_sel == mb_sel) return (ma_t <= mb_t) ? 1 : 2;
`ifdef RF_ARB_RR_EN
      return m_rrb ? 2 : 1;
`else
      return 1;
`endif
    end
    if (ma_full) return 1;
    if (mb_full) return 2;
    return 0;
  endfunction

  task automatic step(bit av, logic [2:0] as, logic [15:0] ad,
                      bit bv, logic [2:0] bs, logic [15:0] bd);
    int w;
    bit ar, br, conflict;
    logic [7:0] pm;
    if (hold_a) begin av = 1; as = pa_sel; ad = pa_data; end
    if (hold_b) begin bv = 1; bs = pb_sel; bd = pb_data; end
    w = pick();
    ar = !ma_full || (w == 1);
    br = !mb_full || (w == 2);
    a_valid = av; a_sel = as; a_data = ad;
    b_valid = bv; b_sel = bs; b_data = bd;
    #1;
    check_eq("a_ready", a_ready, ar);
    check_eq("b_ready", b_ready, br);
    conflict = ma_full && mb_full && (ma_sel != mb_sel);
    m_en = (w != 0);
    if (w == 1) begin m_sel = ma_sel; m_data = ma_data; ma_full = 0; end
    if (w == 2) begin m_sel = mb_sel; m_data = mb_data; mb_full = 0; end
    if (conflict) m_rrb = (w == 1);
    if (av && ar) begin
      ma_full = 1; ma_sel = as; ma_data = ad; ma_t = cyc; accepted++;
    end
    if (bv && br) begin
      mb_full = 1; mb_sel = bs; mb_data = bd; mb_t = cyc; accepted++;
    end
    hold_a = av && !ar; pa_sel = as; pa_data = ad;
    hold_b = bv && !br; pb_sel = bs; pb_data = bd;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    pm = '0;
    if (ma_full) pm[ma_sel] = 1'b1;
    if (mb_full) pm[mb_sel] = 1'b1;
    if (m_en)    pm[m_sel]  = 1'b1;
    check_eq("wr_en", wr_en, m_en);
    check_eq("wr_sel", wr_sel, m_sel);
    check_eq("wr_data", wr_data, m_data);
    check_eq("pend_mask", pend_mask, pm);
    check_eq("busy", busy, ma_full || mb_full || m_en);
    if (wr_en) retired++;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    a_valid = 0; b_valid = 0;
    #1;
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_pend", pend_mask, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_a_ready", a_ready, 0);
    check_eq("rst_b_ready", b_ready, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] first;
    model_clear();
    cyc = 0;
    repeat (2) @(negedge clk);
    check_eq("init_wr_en", wr_en, 0);
    check_eq("init_pend", pend_mask, 0);
    check_eq("init_a_ready", a_ready, 0);
    check_eq("init_b_ready", b_ready, 0);
    rst = 1'b1;

    // single write
    step(1, 3'd3, 16'hBEEF, 0, '0, '0);
    check_eq("single_pend0", pend_mask[3], 1);
    check_eq("single_en0", wr_en, 0);
    idle();
    check_eq("single_en1", wr_en, 1);
    check_eq("single_sel", wr_sel, 3);
    check_eq("single_data", wr_data, 16'hBEEF);
    check_eq("single_pend1", pend_mask[3], 1);
    idle();
    check_eq("single_pend2", pend_mask[3], 0);

    // different-register conflicts
    for (int k = 0; k < 4; k++) begin
`ifdef RF_ARB_RR_EN
      first = (k % 2 == 0) ? 3'd1 : 3'd2;
`else
      first = 3'd1;
`endif
      step(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222);
      idle();
      check_eq("conf_first", wr_sel, first);
      idle();
      check_eq("conf_second", wr_sel, (first == 3'd1) ? 3'd2 : 3'd1);
    end

    // same-register ordering: older B entry retires before newer A
    step(1, 3'd6, 16'h6666, 1, 3'd5, 16'hAAAA);
    step(1, 3'd5, 16'h5555, 0, '0, '0);
    check_eq("ord_a", wr_data, 16'h6666);
    idle();
    check_eq("ord_b_old", wr_data, 16'hAAAA);
    idle();
    check_eq("ord_sel", wr_sel, 5);
    check_eq("ord_final", wr_data, 16'h5555);
    idle();

    // random traffic, saturated phases, one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      int pv;
      pv = (i < 1000) ? 100 : 65;
      if (i == 1500) mid_reset();
      step(($urandom % 100) < pv, 3'($urandom_range(0, 3)), 16'($urandom),
           ($urandom % 100) < pv, 3'($urandom_range(0, 3)), 16'($urandom));
    end

    for (int i = 0; i < 8; i++) idle();
    check_eq("drain_count", retired, accepted);
    check_eq("drain_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
